// File: rtl/updown_bcd_counter_if.sv
// Bundles the count-request inputs and display outputs of updown_bcd_counter.
// Latency: none, wires only.
// Backpressure: none; enable is a one-cycle request that is always accepted.
interface updown_bcd_counter_if;
  logic       enable;
  logic       up_down;
  logic [3:0] units;
  logic [3:0] tens;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic       tc;

  // Stimulus side: drives requests, observes the display.
  modport master (
    output enable, up_down,
    input  units, tens, hex0, hex1, tc
  );

  // Counter side.
  modport slave (
    input  enable, up_down,
    output units, tens, hex0, hex1, tc
  );
endinterface

// File: rtl/updown_bcd_counter.sv
// Two-digit BCD up/down counter with registered active-low seven-segment drivers.
// Latency: one cycle; a step sampled at edge N is visible on every output right after edge N.
// Backpressure: none; every enable cycle is one step. Macro LEADING_ZERO_BLANK_EN blanks hex1 when tens=0.
module updown_bcd_counter #(
  parameter int unsigned MAX_VALUE = 99,  // legal 1..99
  parameter bit          WRAP      = 1'b1 // 1 = wrap at limits, 0 = saturate
) (
  input logic              clk,
  input logic              reset,         // asynchronous, active-low
  updown_bcd_counter_if.slave bus
);

  localparam logic [3:0] MAX_TENS  = 4'(MAX_VALUE / 10);
  localparam logic [3:0] MAX_UNITS = 4'(MAX_VALUE % 10);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HEX1_RST = 7'h7F;
`else
  localparam logic [6:0] HEX1_RST = 7'h40;
`endif

  // Active-low segment pattern, bit order gfedcba; anything outside 0..9 blanks.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [3:0] units_q, tens_q;
  logic [3:0] units_nxt, tens_nxt;
  logic       tc_q, tc_nxt;
  logic [6:0] hex0_q, hex1_q;
  logic [6:0] hex1_nxt;
  logic       at_max, at_zero;

  assign at_max  = (tens_q == MAX_TENS) && (units_q == MAX_UNITS);
  assign at_zero = (tens_q == 4'd0) && (units_q == 4'd0);

  // Next digit values and limit pulse for this cycle's request.
  always_comb begin
    units_nxt = units_q;
    tens_nxt  = tens_q;
    tc_nxt    = 1'b0;
    if (bus.enable) begin
      if (bus.up_down) begin
        if (at_max) begin
          tc_nxt = 1'b1;
          if (WRAP) begin
            units_nxt = 4'd0;
            tens_nxt  = 4'd0;
          end
        end else if (units_q == 4'd9) begin
          units_nxt = 4'd0;
          tens_nxt  = tens_q + 4'd1;
        end else begin
          units_nxt = units_q + 4'd1;
        end
      end else begin
        if (at_zero) begin
          tc_nxt = 1'b1;
          if (WRAP) begin
            units_nxt = MAX_UNITS;
            tens_nxt  = MAX_TENS;
          end
        end else if (units_q == 4'd0) begin
          units_nxt = 4'd9;
          tens_nxt  = tens_q - 4'd1;
        end else begin
          units_nxt = units_q - 4'd1;
        end
      end
    end
  end

  // Tens display pattern, decoded from the next value so it lands with the digits.
  always_comb begin
    hex1_nxt = seg7(tens_nxt);
`ifdef LEADING_ZERO_BLANK_EN
    if (tens_nxt == 4'd0) hex1_nxt = 7'h7F;
`endif
  end

  // All outputs share one register stage so digits and segments never disagree.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      tc_q    <= 1'b0;
      hex0_q  <= 7'h40;
      hex1_q  <= HEX1_RST;
    end else begin
      units_q <= units_nxt;
      tens_q  <= tens_nxt;
      tc_q    <= tc_nxt;
      hex0_q  <= seg7(units_nxt);
      hex1_q  <= hex1_nxt;
    end
  end

  assign bus.units = units_q;
  assign bus.tens  = tens_q;
  assign bus.tc    = tc_q;
  assign bus.hex0  = hex0_q;
  assign bus.hex1  = hex1_q;

endmodule
